// File: rtl/dtw_addr_gen_param_pkg.sv
// DTW address generator shared definitions.
// State and host status codes, default geometry, state class helper.
package dtw_addr_gen_param_pkg;

    localparam int DEF_ADDR_W  = 8;
    localparam int DEF_MAX_LEN = 256;

    typedef enum logic [3:0] {
        ST_IDLE       = 4'd0,
        ST_TFILL      = 4'd1,
        ST_QFILL      = 4'd2,
        ST_FIRST_CELL = 4'd3,
        ST_FIRST_ROW  = 4'd4,
        ST_ROW_FIRST  = 4'd5,
        ST_ROW        = 4'd6,
        ST_DONE       = 4'd9
    } dtw_state_e;

    typedef enum logic [1:0] {
        SYS_IDLE    = 2'b00,
        SYS_TFILL   = 2'b01,
        SYS_QFILL   = 2'b10,
        SYS_COMPUTE = 2'b11
    } sys_status_e;

    function automatic logic is_compute(input dtw_state_e s);
        return (s == ST_FIRST_CELL) || (s == ST_FIRST_ROW) ||
               (s == ST_ROW_FIRST)  || (s == ST_ROW);
    endfunction

endpackage

// File: rtl/dtw_addr_gen_param_cell_pacer.sv
// Per-cell pacing counter for the DTW address generator.
// Counts enabled clocks and pulses on the last clock of each cell.
module dtw_addr_gen_param_cell_pacer #(
    parameter int CELL_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic strobe
);

    localparam int CW = $clog2(CELL_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(CELL_CYCLES - 1);

    logic [CW-1:0] cnt;
    logic          term;

    assign term = (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= term ? '0 : cnt + 1'b1;
        end
    end

    // A clear (abort or leaving compute) suppresses the pulse
    assign strobe = en && term && !clr;

endmodule

// File: rtl/dtw_addr_gen_param.sv
// DTW cost-matrix address sequencer with runtime lengths.
// Walks rows of a TEST_LEN x TEMP_LEN matrix over ping-pong row banks.
module dtw_addr_gen_param
    import dtw_addr_gen_param_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int MAX_LEN     = DEF_MAX_LEN,
    parameter int CELL_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        sys_status,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic              en,
    input  logic [ADDR_W:0]   cfg_temp_len,
    input  logic [ADDR_W:0]   cfg_test_len,
    output logic [3:0]        dtw_state,
    output logic [ADDR_W-1:0] temp_mem_addr,
    output logic [ADDR_W-1:0] test_mem_addr,
    output logic [ADDR_W-1:0] even_addra,
    output logic [ADDR_W-1:0] even_addrb,
    output logic [ADDR_W-1:0] odd_addra,
    output logic [ADDR_W-1:0] odd_addrb,
    output logic              cur_bank,
    output logic              first_row,
    output logic              first_col,
    output logic              cell_strobe,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   result_addr
);

    localparam int LW = ADDR_W + 1;
    localparam logic [LW-1:0] MAX_L = LW'(MAX_LEN);

    dtw_state_e        state, state_n;
    logic [ADDR_W-1:0] row, row_n;
    logic [ADDR_W-1:0] col, col_n;
    logic [ADDR_W-1:0] colm1;
    logic [ADDR_W-1:0] n_last;
    logic [LW-1:0]     n_len, n_len_n;
    logic [LW-1:0]     m_len, m_len_n;
    logic [LW-1:0]     n_in, m_in;
    logic              compute;
    logic              abort;
    logic              pacer_clr;
    logic              strobe;
    logic              col_last;
    logic              row_last;

    assign compute   = is_compute(state);
    assign abort     = compute && (sys_status == SYS_IDLE);
    assign pacer_clr = !compute || abort;

    dtw_addr_gen_param_cell_pacer #(
        .CELL_CYCLES(CELL_CYCLES)
    ) u_pacer (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .clr   (pacer_clr),
        .strobe(strobe)
    );

    assign cell_strobe = strobe;

    // Zero or oversize lengths fall back to the full matrix
    assign n_in = (cfg_temp_len == '0 || cfg_temp_len > MAX_L)
                ? MAX_L : cfg_temp_len;
    assign m_in = (cfg_test_len == '0 || cfg_test_len > MAX_L)
                ? MAX_L : cfg_test_len;

    assign col_last = ({1'b0, col} == n_len - 1'b1);
    assign row_last = ({1'b0, row} == m_len - 1'b1);
    assign n_last   = ADDR_W'(n_len - 1'b1);
    assign colm1    = (col == '0) ? '0 : col - 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            row   <= '0;
            col   <= '0;
            n_len <= '0;
            m_len <= '0;
        end else begin
            state <= state_n;
            row   <= row_n;
            col   <= col_n;
            n_len <= n_len_n;
            m_len <= m_len_n;
        end
    end

    always_comb begin
        state_n = state;
        row_n   = row;
        col_n   = col;
        n_len_n = n_len;
        m_len_n = m_len;
        unique case (state)
            ST_IDLE, ST_TFILL, ST_QFILL: begin
                unique case (sys_status)
                    SYS_IDLE:  state_n = ST_IDLE;
                    SYS_TFILL: state_n = ST_TFILL;
                    SYS_QFILL: state_n = ST_QFILL;
                    default: begin
                        state_n = ST_FIRST_CELL;
                        n_len_n = n_in;
                        m_len_n = m_in;
                        row_n   = '0;
                        col_n   = '0;
                    end
                endcase
            end
            ST_FIRST_CELL, ST_FIRST_ROW, ST_ROW_FIRST, ST_ROW: begin
                if (abort) begin
                    state_n = ST_IDLE;
                    row_n   = '0;
                    col_n   = '0;
                end else if (strobe) begin
                    if (!col_last) begin
                        col_n   = col + 1'b1;
                        state_n = (row == '0) ? ST_FIRST_ROW : ST_ROW;
                    end else if (!row_last) begin
                        row_n   = row + 1'b1;
                        col_n   = '0;
                        state_n = ST_ROW_FIRST;
                    end else begin
                        state_n = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (sys_status == SYS_IDLE) begin
                    state_n = ST_IDLE;
                    row_n   = '0;
                    col_n   = '0;
                end
            end
            default: begin
                state_n = ST_IDLE;
                row_n   = '0;
                col_n   = '0;
            end
        endcase
    end

    assign dtw_state = state;

    always_comb begin
        temp_mem_addr = '0;
        test_mem_addr = '0;
        even_addra    = '0;
        even_addrb    = '0;
        odd_addra     = '0;
        odd_addrb     = '0;
        cur_bank      = 1'b0;
        first_row     = 1'b0;
        first_col     = 1'b0;
        busy          = 1'b0;
        done          = 1'b0;
        result_addr   = '0;
        unique case (1'b1)
            state == ST_TFILL: temp_mem_addr = data_addr;
            state == ST_QFILL: test_mem_addr = data_addr;
            compute: begin
                busy          = 1'b1;
                cur_bank      = row[0];
                first_row     = (row == '0);
                first_col     = (col == '0);
                temp_mem_addr = col;
                test_mem_addr = row;
                // Even is written on even rows and read as up/diag on odd ones
                even_addra    = col;
                even_addrb    = colm1;
                if (row != '0) begin
                    odd_addra = col;
                    odd_addrb = colm1;
                end
            end
            state == ST_DONE: begin
                done        = 1'b1;
                odd_addra   = n_last;
                result_addr = {~m_len[0], n_last};
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_dtw_addr_gen_param.sv
// Scoreboard bench for the DTW address sequencer.
// Expected cells are queued at start and popped on each strobe.
module tb_dtw_addr_gen_param;

    logic       clk;
    logic       rst_n;
    logic [1:0] sys_status;
    logic [7:0] data_addr;
    logic       en;
    logic [8:0] cfg_temp_len;
    logic [8:0] cfg_test_len;
    logic [3:0] dtw_state;
    logic [7:0] temp_mem_addr;
    logic [7:0] test_mem_addr;
    logic [7:0] even_addra;
    logic [7:0] even_addrb;
    logic [7:0] odd_addra;
    logic [7:0] odd_addrb;
    logic       cur_bank;
    logic       first_row;
    logic       first_col;
    logic       cell_strobe;
    logic       busy;
    logic       done;
    logic [8:0] result_addr;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        int cyc;
        int temp;
        int test;
        int ea;
        int eb;
        int oa;
        int ob;
        int bank;
        int fr;
        int fc;
    } cell_t;

    cell_t q[$];

    dtw_addr_gen_param #(
        .ADDR_W     (8),
        .MAX_LEN    (256),
        .CELL_CYCLES(16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sys_status   (sys_status),
        .data_addr    (data_addr),
        .en           (en),
        .cfg_temp_len (cfg_temp_len),
        .cfg_test_len (cfg_test_len),
        .dtw_state    (dtw_state),
        .temp_mem_addr(temp_mem_addr),
        .test_mem_addr(test_mem_addr),
        .even_addra   (even_addra),
        .even_addrb   (even_addrb),
        .odd_addra    (odd_addra),
        .odd_addrb    (odd_addrb),
        .cur_bank     (cur_bank),
        .first_row    (first_row),
        .first_col    (first_col),
        .cell_strobe  (cell_strobe),
        .busy         (busy),
        .done         (done),
        .result_addr  (result_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_state"}, int'(dtw_state), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_strobe"}, int'(cell_strobe), 0);
        chk({tag, "_temp"}, int'(temp_mem_addr), 0);
        chk({tag, "_test"}, int'(test_mem_addr), 0);
        chk({tag, "_ea"}, int'(even_addra), 0);
        chk({tag, "_oa"}, int'(odd_addra), 0);
        chk({tag, "_frow"}, int'(first_row), 0);
        chk({tag, "_res"}, int'(result_addr), 0);
    endtask

    task automatic push_cells(input int n, input int m,
                              input int per, input int off);
        cell_t e;
        for (int r = 0; r < m; r++) begin
            for (int c = 0; c < n; c++) begin
                int cm1;
                cm1    = (c == 0) ? 0 : c - 1;
                e.cyc  = per * (r * n + c + 1) - off;
                e.temp = c;
                e.test = r;
                e.bank = r % 2;
                e.fr   = (r == 0) ? 1 : 0;
                e.fc   = (c == 0) ? 1 : 0;
                e.ea   = c;
                e.eb   = cm1;
                e.oa   = (r == 0) ? 0 : c;
                e.ob   = (r == 0) ? 0 : cm1;
                q.push_back(e);
            end
        end
    endtask

    task automatic run(input int cfg_n, input int cfg_m,
                       input int exp_n, input int exp_m,
                       input bit tog, input int stop_cyc,
                       input bit use_rst);
        int per;
        int off;
        int budget;
        bit fin;
        cell_t e;
        per    = tog ? 32 : 16;
        off    = tog ? 2 : 1;
        budget = exp_n * exp_m * per + 50;
        fin    = 1'b0;
        push_cells(exp_n, exp_m, per, off);
        @(negedge clk);
        cfg_temp_len = 9'(cfg_n);
        cfg_test_len = 9'(cfg_m);
        en           = 1'b1;
        sys_status   = 2'b11;
        @(posedge clk);
        for (int k = 0; k < budget && !fin; k++) begin
            @(negedge clk);
            en = tog ? (k % 2 == 0) : 1'b1;
            if (k == stop_cyc) begin
                if (use_rst) begin
                    #1 rst_n = 1'b0;
                    #1 chk_idle_outputs("rst_mid");
                    @(negedge clk);
                    sys_status = 2'b00;
                    rst_n      = 1'b1;
                end else begin
                    sys_status = 2'b00;
                    #1;
                    chk("abort_strobe", int'(cell_strobe), 0);
                    chk("abort_busy_pre", int'(busy), 1);
                    @(posedge clk);
                    #1 chk_idle_outputs("abort");
                end
                q.delete();
                fin = 1'b1;
            end else begin
                #1;
                if (cell_strobe) begin
                    if (q.size() == 0) begin
                        chk("extra_strobe", k, -1);
                    end else begin
                        e = q.pop_front();
                        chk("strobe_cyc", k, e.cyc);
                        chk("temp", int'(temp_mem_addr), e.temp);
                        chk("test", int'(test_mem_addr), e.test);
                        chk("even_a", int'(even_addra), e.ea);
                        chk("even_b", int'(even_addrb), e.eb);
                        chk("odd_a", int'(odd_addra), e.oa);
                        chk("odd_b", int'(odd_addrb), e.ob);
                        chk("cur_bank", int'(cur_bank), e.bank);
                        chk("first_row", int'(first_row), e.fr);
                        chk("first_col", int'(first_col), e.fc);
                        chk("busy", int'(busy), 1);
                    end
                end
                if (done) begin
                    chk("done_cyc", k, per * exp_n * exp_m - off + 1);
                    chk("done_state", int'(dtw_state), 9);
                    chk("done_busy", int'(busy), 0);
                    chk("done_strobe", int'(cell_strobe), 0);
                    chk("result_addr", int'(result_addr),
                        ((exp_m - 1) % 2) * 256 + exp_n - 1);
                    chk("done_odd_a", int'(odd_addra), exp_n - 1);
                    fin = 1'b1;
                end
            end
        end
        if (!fin) chk("timeout", 0, 1);
        chk("missing_strobes", q.size(), 0);
        q.delete();
        @(negedge clk);
        sys_status = 2'b00;
        @(posedge clk);
        #1 chk("back_idle", int'(dtw_state), 0);
    endtask

    initial begin
        rst_n        = 1'b0;
        sys_status   = 2'b00;
        data_addr    = 8'd0;
        en           = 1'b0;
        cfg_temp_len = 9'd0;
        cfg_test_len = 9'd0;
        #12 chk_idle_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        sys_status = 2'b01;
        @(posedge clk);
        for (int a = 0; a < 256; a++) begin
            @(negedge clk);
            data_addr = 8'(a);
            #1;
            chk("tfill_temp", int'(temp_mem_addr), a);
            chk("tfill_test", int'(test_mem_addr), 0);
            chk("tfill_busy", int'(busy), 0);
        end
        chk("tfill_state", int'(dtw_state), 1);
        @(negedge clk);
        sys_status = 2'b10;
        @(posedge clk);
        for (int a = 0; a < 8; a++) begin
            @(negedge clk);
            data_addr = 8'(a * 37 + 5);
            #1;
            chk("qfill_test", int'(test_mem_addr), (a * 37 + 5) % 256);
            chk("qfill_temp", int'(temp_mem_addr), 0);
            chk("qfill_state", int'(dtw_state), 2);
        end
        @(negedge clk);
        sys_status = 2'b00;
        @(posedge clk);

        run(4, 4, 4, 4, 1'b0, -1, 1'b0);
        run(2, 2, 2, 2, 1'b1, -1, 1'b0);
        run(4, 4, 4, 4, 1'b0, 95, 1'b0);
        run(0, 2, 256, 2, 1'b0, -1, 1'b0);
        run(1, 300, 1, 256, 1'b0, -1, 1'b0);
        run(3, 2, 3, 2, 1'b1, -1, 1'b0);
        run(4, 4, 4, 4, 1'b0, 100, 1'b1);
        run(1, 1, 1, 1, 1'b0, -1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
